// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
//   Shared definitions for the pipelined carry-lookahead adder.
//   - GROUP_W    : width of one lookahead group (4 bits)
//   - CLA_MAX_W  : widest operand the stage payload struct can carry
//   - cla_stages : pipeline depth L for a given WIDTH / PIPE_GROUPS
//   - cla_stage_t: payload held in every pipeline stage register
// -----------------------------------------------------------------------------
package cla_pkg;

  localparam int GROUP_W   = 4;
  localparam int CLA_MAX_W = 64;

  // Number of register stages: each stage resolves PIPE_GROUPS 4-bit groups.
  function automatic int cla_stages(input int width, input int pipe_groups);
    return width / (GROUP_W * pipe_groups);
  endfunction

  // Stage payload. sum holds every slice resolved so far (lower slices ride
  // along unchanged); a_rem/b_rem hold the operands still to be consumed, with
  // b already inverted for subtraction. Fields are sized for the widest build;
  // only the low WIDTH bits are meaningful.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [CLA_MAX_W-1:0] sum;
    logic [CLA_MAX_W-1:0] a_rem;
    logic [CLA_MAX_W-1:0] b_rem;
  } cla_stage_t;

endpackage

// File: rtl/cla_pipe_adder_if.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder_if
//   Operand/result handshake bundle for cla_pipe_adder.
//   master: produces operands (in_valid, a, b, cin, sub) and out_ready.
//   slave : the adder; produces in_ready, out_valid, sum, cout (and ovf).
//   Optional: ovf exists only when CLA_PIPE_OVF_EN is defined.
// -----------------------------------------------------------------------------
interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CLA_PIPE_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout
`ifdef CLA_PIPE_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout
`ifdef CLA_PIPE_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/cla_group4.sv
// -----------------------------------------------------------------------------
// cla_group4
//   4-bit carry-lookahead group.
//   a, b : operand nibbles
//   c_in : carry into bit 0
//   s    : sum nibble
//   g, p : group generate / propagate for the next lookahead level
// -----------------------------------------------------------------------------
module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       g,
  output logic       p
);

  logic [3:0] gi;
  logic [3:0] pi;
  logic [3:1] c;

  assign gi = a & b;
  assign pi = a ^ b;

  // Flat lookahead: every internal carry depends only on gi/pi and c_in.
  assign c[1] = gi[0] | (pi[0] & c_in);
  assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & c_in);
  assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
              | (pi[2] & pi[1] & pi[0] & c_in);

  assign s = pi ^ {c[3:1], c_in};

  // g/p never depend on c_in, so the next level can chain groups freely.
  assign g = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
           | (pi[3] & pi[2] & pi[1] & gi[0]);
  assign p = &pi;

endmodule

// File: rtl/cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder
//   Pipelined carry-lookahead adder/subtractor. WIDTH-bit operands are split
//   into 4-bit groups; each of the L = WIDTH/(4*PIPE_GROUPS) register stages
//   resolves PIPE_GROUPS groups and hands its carry to the next stage.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : cla_pipe_adder_if.slave (in_valid/in_ready/a/b/cin/sub,
//             out_valid/out_ready/sum/cout[/ovf])
//   Optional: CLA_PIPE_OVF_EN adds the registered signed-overflow output ovf.
// -----------------------------------------------------------------------------
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int PIPE_GROUPS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  cla_pipe_adder_if.slave     bus
);

  localparam int L  = cla_stages(WIDTH, PIPE_GROUPS);
  localparam int SW = GROUP_W * PIPE_GROUPS;   // bits resolved per stage
  localparam int NG = WIDTH / GROUP_W;         // total lookahead groups

  cla_stage_t stage_q  [L];   // stage registers
  cla_stage_t stage_in [L];   // payload entering each stage's logic
  cla_stage_t nxt      [L];   // payload captured by each stage
  cla_stage_t head;           // payload built from the input ports

  logic [3:0]       grp_a [NG];
  logic [3:0]       grp_b [NG];
  logic [NG-1:0]    c_grp;
  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [WIDTH-1:0] grp_s;
  logic [L-1:0]     st_c_out;
  logic             adv;

  // Whole pipe moves together; a full pipe only stalls on out_ready=0.
  assign adv          = bus.out_ready | ~stage_q[L-1].valid;
  assign bus.in_ready = adv;

  // Subtraction is a + ~b + 1: invert b here and force the carry-in to 1.
  // NOTE: every always_comb output gets a full default first so no path
  // leaves a bit unassigned and infers a latch.
  always_comb begin
    head                   = '0;
    head.valid             = bus.in_valid;
    head.carry             = bus.sub | bus.cin;
    head.a_rem[WIDTH-1:0]  = bus.a;
    head.b_rem[WIDTH-1:0]  = bus.b ^ {WIDTH{bus.sub}};
  end

  for (genvar k = 0; k < L; k++) begin : g_stage_in
    if (k == 0) begin : g_head
      assign stage_in[k] = head;
    end else begin : g_chain
      assign stage_in[k] = stage_q[k-1];
    end
  end

  for (genvar g = 0; g < NG; g++) begin : g_grp
    localparam int K = g / PIPE_GROUPS;
    assign grp_a[g] = stage_in[K].a_rem[GROUP_W*g +: GROUP_W];
    assign grp_b[g] = stage_in[K].b_rem[GROUP_W*g +: GROUP_W];

    cla_group4 u_grp (
      .a    (grp_a[g]),
      .b    (grp_b[g]),
      .c_in (c_grp[g]),
      .s    (grp_s[GROUP_W*g +: GROUP_W]),
      .g    (gg[g]),
      .p    (gp[g])
    );
  end

  // Group-level lookahead. The chain restarts at each stage boundary from
  // that stage's registered carry, so no carry path crosses a register.
  always_comb begin
    logic c;
    c        = 1'b0;
    c_grp    = '0;
    st_c_out = '0;
    for (int g = 0; g < NG; g++) begin
      if (g % PIPE_GROUPS == 0) c = stage_in[g / PIPE_GROUPS].carry;
      c_grp[g] = c;
      c        = gg[g] | (gp[g] & c);
      if (g % PIPE_GROUPS == PIPE_GROUPS - 1) st_c_out[g / PIPE_GROUPS] = c;
    end
  end

  // Each stage forwards everything it received and fills in its own slice.
  always_comb begin
    for (int k = 0; k < L; k++) begin
      nxt[k]                  = stage_in[k];
      nxt[k].carry            = st_c_out[k];
      nxt[k].sum[k*SW +: SW]  = grp_s[k*SW +: SW];
    end
  end

`ifdef CLA_PIPE_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c.
  assign ovf_d   = (grp_a[NG-1][3] ^ grp_b[NG-1][3] ^ grp_s[WIDTH-1])
                 ^ st_c_out[L-1];
  assign bus.ovf = ovf_q;
`endif

  // NOTE: the data fields are reset along with the valid bits because the
  // final stage drives sum/cout directly and they must read 0 out of reset.
  // NOTE: sequential state uses non-blocking assignments so all stages
  // sample their predecessors' old values on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < L; k++) stage_q[k] <= '0;
`ifdef CLA_PIPE_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (adv) begin
      for (int k = 0; k < L; k++) stage_q[k] <= nxt[k];
`ifdef CLA_PIPE_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign bus.out_valid = stage_q[L-1].valid;
  assign bus.sum       = stage_q[L-1].sum[WIDTH-1:0];
  assign bus.cout      = stage_q[L-1].carry;

  // The last stage's leftover operand bits and the unused upper field bits
  // have no consumer; fold them into a single sink.
  logic unused_tail;
  assign unused_tail = ^stage_q[L-1];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_pipe_adder
//   Self-checking bench for cla_pipe_adder (WIDTH=16, PIPE_GROUPS=1, L=4).
//   A table of hand-computed vectors is streamed through the pipe with a
//   queue of expected indices; reset, latency, stall and mid-flight reset
//   are covered by short directed sequences. ovf is checked when
//   CLA_PIPE_OVF_EN is defined.
// -----------------------------------------------------------------------------
module tb_cla_pipe_adder;

  localparam int W  = 16;
  localparam int L  = 4;
  localparam int NV = 10;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  vec_t vecs [NV];

  cla_pipe_adder_if #(.WIDTH(W)) bus ();

  cla_pipe_adder #(.WIDTH(W), .PIPE_GROUPS(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_vec(input int i);
    bus.a   = vecs[i].a;
    bus.b   = vecs[i].b;
    bus.cin = vecs[i].cin;
    bus.sub = vecs[i].sub;
  endtask

  task automatic check_result(input string tag, input int i);
    check({tag, "_sum"},  32'(bus.sum),  32'(vecs[i].sum));
    check({tag, "_cout"}, 32'(bus.cout), 32'(vecs[i].cout));
`ifdef CLA_PIPE_OVF_EN
    check({tag, "_ovf"},  32'(bus.ovf),  32'(vecs[i].ovf));
`endif
  endtask

  // Streams vecs[first .. first+n-1] back to back. out_ready drops for three
  // cycles starting at cycle stall_at (negative: never). Every retired result
  // is matched against the oldest accepted vector.
  task automatic run_stream(input string tag, input int first, input int n, input int stall_at);
    int           sent = 0;
    int           got  = 0;
    int           cyc  = 0;
    int           idx;
    int           exp_q [$];
    logic         held_v = 1'b0;
    logic [W-1:0] held_sum = '0;
    logic         held_cout = 1'b0;
    while ((got < n) && (cyc < 200)) begin
      @(negedge clk);
      bus.out_ready = !((stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + 3));
      if (sent < n) begin
        drive_vec(first + sent);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (held_v) begin
        check({tag, "_hold_sum"},  32'(bus.sum),  32'(held_sum));
        check({tag, "_hold_cout"}, 32'(bus.cout), 32'(held_cout));
      end
      held_v = 1'b0;
      if (bus.out_valid && !bus.out_ready) begin
        check({tag, "_stall_in_ready"}, 32'(bus.in_ready), 32'd0);
        held_v    = 1'b1;
        held_sum  = bus.sum;
        held_cout = bus.cout;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check({tag, "_spurious_out"}, 32'd1, 32'd0);
        end else begin
          idx = exp_q.pop_front();
          check_result($sformatf("%s_v%0d", tag, idx), idx);
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(first + sent);
        sent++;
      end
      cyc++;
    end
    check({tag, "_retired_count"}, 32'(got), 32'(n));
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1 check({tag, "_no_extra"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int   wait_cnt;
    logic seen;
    checks   = 0;
    failures = 0;

    //              a         b         cin   sub   sum       cout  ovf
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[2] = '{16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[7] = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[9] = '{16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0};

    // Reset state
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum",       32'(bus.sum),       32'd0);
    check("rst_cout",      32'(bus.cout),      32'd0);
`ifdef CLA_PIPE_OVF_EN
    check("rst_ovf",       32'(bus.ovf),       32'd0);
`endif
    rst_n = 1'b1;
    #1 check("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // Latency: full carry ripple, result after exactly L edges
    @(negedge clk);
    bus.out_ready = 1'b1;
    drive_vec(0);
    bus.in_valid = 1'b1;
    #1 check("lat_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 1; i < L; i++) begin
      #1 check($sformatf("lat_early_%0d", i), 32'(bus.out_valid), 32'd0);
      @(negedge clk);
    end
    #1 check("lat_out_valid", 32'(bus.out_valid), 32'd1);
    check_result("lat", 0);

    // Back-to-back beats
    run_stream("b2b", 1, 3, -1);

    // Subtract and misc vectors with a three-cycle stall in the middle
    run_stream("stall", 4, 6, 6);

    // Reset with beats in flight and a result waiting at the output
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive_vec(1);
    bus.in_valid = 1'b1;
    @(negedge clk);
    drive_vec(2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_cnt = 0;
    while (!bus.out_valid && (wait_cnt < 20)) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("mid_fill_out_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_sum", 32'(bus.sum), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    seen = 1'b0;
    repeat (2 * L + 2) begin
      @(negedge clk);
      #1 if (bus.out_valid) seen = 1'b1;
    end
    check("mid_no_stale", 32'(seen), 32'd0);
    run_stream("post_rst", 9, 1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
